// File: rtl/instruction_queue.sv
// instruction_queue: DEPTH-entry first-in-first-out instruction buffer between
// instruction memory and the control unit. Words load at the tail. The head
// entry is always presented, split into opcode and operand fields. Flush
// discards all entries, and a sticky flag records any dropped load.
//
// Ports:
//   clk    - single clock, all state updates on rising edge
//   rst    - asynchronous active-low reset, clears all state immediately
//   ldir   - load request: push data at the tail
//   data   - instruction word to load
//   rdir   - consume request: pop the head entry
//   flush  - discard all entries (highest priority)
//   opcode - top OPCODE_W bits of the head word, 0 when empty
//   irout  - remaining low bits of the head word, 0 when empty
//   valid  - queue non-empty, head fields meaningful
//   full   - count == DEPTH
//   count  - number of occupied entries
//   ovf    - sticky: a load was dropped because the queue was full
module instruction_queue #(
   parameter int unsigned INSTR_W  = 32,
   parameter int unsigned OPCODE_W = 4,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ldir,
   input  logic [INSTR_W-1:0]            data,
   input  logic                          rdir,
   input  logic                          flush,
   output logic [OPCODE_W-1:0]           opcode,
   output logic [INSTR_W-OPCODE_W-1:0]   irout,
   output logic                          valid,
   output logic                          full,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic                          ovf
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned OPND_W = INSTR_W - OPCODE_W;

   // Elaboration-time parameter sanity checks.
   if (OPCODE_W >= INSTR_W) begin : g_bad_opcode_w
      $error("instruction_queue: OPCODE_W must be smaller than INSTR_W");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("instruction_queue: DEPTH must be a power of two and >= 2");
   end

   // Storage and control state.
   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [INSTR_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]   wp_q, wp_d;
   logic [PTR_W-1:0]   rp_q, rp_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               valid_q, valid_d;
   logic               full_q, full_d;
   logic               ovf_q, ovf_d;

   // Handshake qualification.
   logic               pop_ok;
   logic               push_ok;
   logic               drop;
   logic [INSTR_W-1:0] head;

   // Flush masks both requests. A pop frees a slot in the same cycle, so a
   // full queue can still accept a load alongside it.
   always_comb begin
      pop_ok  = rdir && valid_q && !flush;
      push_ok = ldir && (!full_q || pop_ok) && !flush;
      drop    = ldir && full_q && !pop_ok && !flush;
   end

   // Pointer, occupancy and overflow next-state.
   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         if (push_ok) begin
            wp_d = wp_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rp_d = rp_q + PTR_W'(1);
         end
         if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
         end
         if (drop) begin
            ovf_d = 1'b1;
         end
      end
      // Status flags are registered alongside count so they track post-edge state.
      valid_d = (count_d != '0);
      full_d  = (count_d == CNT_W'(DEPTH));
   end

   // Array write at the tail.
   always_comb begin
      mem_d = mem_q;
      if (push_ok) begin
         mem_d[wp_q] = data;
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         valid_q <= valid_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
      end
   end

   // Array contents are not reset; unoccupied entries are never presented.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // First-word-fall-through head presentation, zero-masked while empty.
   always_comb begin
      head   = mem_q[rp_q];
      opcode = '0;
      irout  = '0;
      if (valid_q) begin
         opcode = head[INSTR_W-1 -: OPCODE_W];
         irout  = head[OPND_W-1:0];
      end
   end

   assign valid = valid_q;
   assign full  = full_q;
   assign count = count_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_instruction_queue.sv
module tb_instruction_queue;

   localparam int unsigned IW = 32;
   localparam int unsigned OW = 4;
   localparam int unsigned D  = 4;
   localparam int unsigned CW = $clog2(D + 1);
   localparam int unsigned RW = IW - OW;

   logic          clk   = 1'b0;
   logic          rst   = 1'b0;
   logic          ldir  = 1'b0;
   logic          rdir  = 1'b0;
   logic          flush = 1'b0;
   logic [IW-1:0] data  = '0;
   logic [OW-1:0] opcode;
   logic [RW-1:0] irout;
   logic          valid;
   logic          full;
   logic [CW-1:0] count;
   logic          ovf;

   always #5 clk = ~clk;

   instruction_queue #(.INSTR_W(IW), .OPCODE_W(OW), .DEPTH(D)) dut (
      .clk    (clk),
      .rst    (rst),
      .ldir   (ldir),
      .data   (data),
      .rdir   (rdir),
      .flush  (flush),
      .opcode (opcode),
      .irout  (irout),
      .valid  (valid),
      .full   (full),
      .count  (count),
      .ovf    (ovf)
   );

   typedef struct packed {
      logic          valid;
      logic          full;
      logic          ovf;
      logic [CW-1:0] cnt;
      logic [OW-1:0] opc;
      logic [RW-1:0] opnd;
   } view_t;

   // Reference model: a plain queue of words plus the sticky flag.
   logic [IW-1:0] mq[$];
   logic          m_ovf = 1'b0;
   view_t         sb[$];
   int            n_cmp = 0;
   int            n_err = 0;
   event          kick;

   function automatic view_t model_view();
      view_t         v;
      logic [IW-1:0] h;
      v       = '0;
      v.valid = (mq.size() > 0);
      v.full  = (mq.size() == int'(D));
      v.ovf   = m_ovf;
      v.cnt   = CW'(mq.size());
      if (mq.size() > 0) begin
         h      = mq[0];
         v.opc  = h[IW-1 -: OW];
         v.opnd = h[RW-1:0];
      end
      return v;
   endfunction

   task automatic model_step(input logic ld, input logic [IW-1:0] d,
                             input logic rd, input logic fl);
      bit is_full, do_pop, do_push;
      if (!rst) begin
         mq.delete();
         m_ovf = 1'b0;
      end else if (fl) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         is_full = (mq.size() == int'(D));
         do_pop  = rd && (mq.size() > 0);
         do_push = ld && (!is_full || do_pop);
         if (ld && is_full && !do_pop) m_ovf = 1'b1;
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back(d);
      end
   endtask

   // One clock of stimulus; the expected post-edge view goes to the scoreboard.
   task automatic cyc(input logic ld, input logic [IW-1:0] d,
                      input logic rd, input logic fl);
      ldir  = ld;
      data  = d;
      rdir  = rd;
      flush = fl;
      @(posedge clk);
      model_step(ld, d, rd, fl);
      sb.push_back(model_view());
      @(negedge clk);
      ldir  = 1'b0;
      rdir  = 1'b0;
      flush = 1'b0;
   endtask

   // Reset asserted between edges with a load pending; checked before the next edge.
   task automatic async_reset();
      ldir = 1'b1;
      data = $urandom;
      rdir = 1'b1;
      #2 rst = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      sb.push_back(model_view());
      #1 ->kick;
      @(negedge clk);
      ldir = 1'b0;
      rdir = 1'b0;
      rst  = 1'b1;
   endtask

   // Monitor: pops one expectation each time the DUT state is sampled.
   initial begin
      view_t e;
      view_t a;
      forever begin
         @(negedge clk or kick);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {valid, full, ovf, count, opcode, irout};
            n_cmp++;
            if (a !== e) begin
               n_err++;
               $display("FAIL head_state t=%0t got v=%b f=%b ovf=%b cnt=%0d opc=%h ir=%h want v=%b f=%b ovf=%b cnt=%0d opc=%h ir=%h",
                        $time, a.valid, a.full, a.ovf, a.cnt, a.opc, a.opnd,
                        e.valid, e.full, e.ovf, e.cnt, e.opc, e.opnd);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t simulation did not finish, want finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      // Power-on reset state.
      #1;
      sb.push_back(model_view());
      ->kick;
      @(negedge clk);
      rst = 1'b1;

      // Load 3 words, then asynchronous reset mid-operation.
      cyc(1'b1, 32'h11111111, 1'b0, 1'b0);
      cyc(1'b1, 32'h22222222, 1'b0, 1'b0);
      cyc(1'b1, 32'h33333333, 1'b0, 1'b0);
      async_reset();

      // Fill and overflow, then drain in order.
      cyc(1'b1, 32'hAABBCCDD, 1'b0, 1'b0);
      cyc(1'b1, 32'h12345678, 1'b0, 1'b0);
      cyc(1'b1, 32'h0000000F, 1'b0, 1'b0);
      cyc(1'b1, 32'hF0000001, 1'b0, 1'b0);
      cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);

      // Flush clears ovf; refill, then full push+pop across the wrap.
      cyc(1'b0, '0, 1'b0, 1'b1);
      cyc(1'b1, 32'hA0000001, 1'b0, 1'b0);
      cyc(1'b1, 32'hB0000002, 1'b0, 1'b0);
      cyc(1'b1, 32'hC0000003, 1'b0, 1'b0);
      cyc(1'b1, 32'hD0000004, 1'b0, 1'b0);
      cyc(1'b1, 32'h55555555, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);

      // Flush priority over same-cycle load and pop, with ovf set beforehand.
      for (int i = 0; i < 5; i++) cyc(1'b1, 32'h70000000 + i, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b1, 32'h6789ABCD, 1'b1, 1'b1);

      // Empty corner: pop ignored, load lands.
      cyc(1'b1, 32'h9ABCDEF0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // Randomized traffic, biased first toward filling then toward draining.
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            async_reset();
         end else if (i < 300) begin
            cyc($urandom_range(0, 99) < 70, $urandom,
                $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 3);
         end else begin
            cyc($urandom_range(0, 99) < 35, $urandom,
                $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3);
         end
      end

      @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
